// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and GF(2^8) helpers
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_expansion_step.sv
// rtl/aes128_key_expansion_step.sv - one AES-128 key expansion round with a runtime rcon
`include "aes_defines.svh"

module aes128_key_expansion_step (
    input  logic [`AES128_KEY_SIZE-1:0] prev_key,
    input  logic [7:0]                  rcon,
    output logic [`AES128_KEY_SIZE-1:0] next_key
);

    logic [`AES_WORD_SIZE-1:0] w3;
    logic [`AES_WORD_SIZE-1:0] rot_w3;
    logic [`AES_WORD_SIZE-1:0] sub_w3;
    logic [`AES_WORD_SIZE-1:0] n0, n1, n2, n3;

    assign w3     = prev_key[`AES_WORD(3)];
    // RotWord moves byte 0 to the top; with byte 0 in the low bits that is a right rotate.
    assign rot_w3 = {w3[7:0], w3[31:8]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_w3[8*b +: 8])
        );
    end

    assign n0 = prev_key[`AES_WORD(0)] ^ sub_w3 ^ {24'h000000, rcon};
    assign n1 = prev_key[`AES_WORD(1)] ^ n0;
    assign n2 = prev_key[`AES_WORD(2)] ^ n1;
    assign n3 = prev_key[`AES_WORD(3)] ^ n2;

    assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/aes_defines.svh
// rtl/aes_defines.svh - shared AES widths, word-slice helpers and round constants
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES128_KEY_SIZE 128
`define AES_WORD_SIZE   32

// Word i of a 128-bit block; word 0 holds FIPS-197 bytes 0..3 with byte 0 in the low bits.
`define AES_WORD(i) ((i) * `AES_WORD_SIZE) +: `AES_WORD_SIZE

`define AES_RCON_01 8'h01
`define AES_RCON_02 8'h02
`define AES_RCON_03 8'h04
`define AES_RCON_04 8'h08
`define AES_RCON_05 8'h10
`define AES_RCON_06 8'h20
`define AES_RCON_07 8'h40
`define AES_RCON_08 8'h80
`define AES_RCON_09 8'h1b
`define AES_RCON_10 8'h36

`endif

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box (GF inverse followed by the affine map)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128 gives the inverse, and maps 0 to 0 as the S-box needs.
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes128_key_scheduler.sv
// rtl/aes128_key_scheduler.sv - iterative AES-128 key expansion into an 11-entry round-key store
`include "aes_defines.svh"

module aes128_key_scheduler
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [`AES128_KEY_SIZE-1:0] key,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic                        rk_rd,
    input  logic [3:0]                  rk_addr,
    output logic [`AES128_KEY_SIZE-1:0] rk_data,
    output logic                        rk_data_valid,
    output logic                        keys_ready
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes128_key_scheduler: NUM_ROUNDS must be 10");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_e                   state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [7:0]                  rcon_q, rcon_d;
    logic [`AES128_KEY_SIZE-1:0] rk_q [0:NUM_ROUNDS];
    logic [`AES128_KEY_SIZE-1:0] rk_d [0:NUM_ROUNDS];
    logic [`AES128_KEY_SIZE-1:0] rk_data_q, rk_data_d;
    logic                        rk_data_valid_q, rk_data_valid_d;
    logic                        keys_ready_q, keys_ready_d;
    logic [`AES128_KEY_SIZE-1:0] step_key;

    aes128_key_expansion_step u_step (
        .prev_key (rk_q[cnt_q - 4'd1]),
        .rcon     (rcon_q),
        .next_key (step_key)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rcon_d          = rcon_q;
        rk_d            = rk_q;
        keys_ready_d    = keys_ready_q;
        rk_data_d       = rk_data_q;
        rk_data_valid_d = 1'b0;

        // Reads see the store as it was before this edge, so a re-key returns the old key.
        if (rk_rd && keys_ready_q) begin
            rk_data_valid_d = 1'b1;
            rk_data_d       = (rk_addr <= LAST_IDX) ? rk_q[rk_addr] : '0;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (key_valid) begin
                    rk_d[0]      = key;
                    cnt_d        = 4'd1;
                    rcon_d       = `AES_RCON_01;
                    keys_ready_d = 1'b0;
                    state_d      = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                rk_d[cnt_q] = step_key;
                cnt_d       = cnt_q + 4'd1;
                rcon_d      = xtime(rcon_q);
                if (cnt_q == LAST_IDX) begin
                    keys_ready_d = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 4'd0;
            rcon_q          <= `AES_RCON_01;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
            rk_data_q       <= '0;
            rk_data_valid_q <= 1'b0;
            keys_ready_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rcon_q          <= rcon_d;
            rk_q            <= rk_d;
            rk_data_q       <= rk_data_d;
            rk_data_valid_q <= rk_data_valid_d;
            keys_ready_q    <= keys_ready_d;
        end
    end

    assign key_ready     = (state_q != ST_EXPAND);
    assign rk_data       = rk_data_q;
    assign rk_data_valid = rk_data_valid_q;
    assign keys_ready    = keys_ready_q;

endmodule

// File: tb/tb_aes128_key_scheduler.sv
// tb/tb_aes128_key_scheduler.sv - randomized self-checking bench against a FIPS-197 expansion model
module tb_aes128_key_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         rk_rd;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_data_valid;
    logic         keys_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sb       [0:255];
    logic [7:0]   rcon_tab [0:9];
    logic [127:0] ref_rk   [0:10];

    aes128_key_scheduler #(.NUM_ROUNDS(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .key           (key),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .rk_rd         (rk_rd),
        .rk_addr       (rk_addr),
        .rk_data       (rk_data),
        .rk_data_valid (rk_data_valid),
        .keys_ready    (keys_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIPS-197 text order (byte 0 first) to the port packing (byte 0 in bits [7:0]).
    function automatic logic [127:0] fips(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127 - 8*i -: 8];
        return r;
    endfunction

    // S-box built by walking the multiplicative group with generator 3 and its inverse.
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    // Word-by-word key expansion over all 44 words.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[7:0] = t[7:0] ^ rcon_tab[i/4 - 1];
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    function automatic logic [127:0] ref_read(input logic [3:0] a);
        return (a <= 4'd10) ? ref_rk[a] : 128'h0;
    endfunction

    task automatic load_key(input logic [127:0] k);
        key       = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check_eq("keys_ready_after_accept", keys_ready, 1'b0);
        check_eq("key_ready_after_accept", key_ready, 1'b0);
        model_expand(k);
    endtask

    // Counts cycles until keys_ready; optionally probes reads that must be ignored.
    task automatic wait_keys(input bit probe_reads, output int lat);
        logic [127:0] held;
        lat = 0;
        while (!keys_ready && lat < 40) begin
            check_eq("key_ready_in_expand", key_ready, 1'b0);
            held = rk_data;
            if (probe_reads) begin
                rk_rd   = 1'b1;
                rk_addr = 4'($urandom_range(0, 15));
            end
            tick();
            lat++;
            rk_rd = 1'b0;
            if (probe_reads) begin
                check_eq("rd_in_expand_valid", rk_data_valid, 1'b0);
                check_eq("rd_in_expand_hold", rk_data, held);
            end
        end
    endtask

    task automatic burst_read(input logic [3:0] addrs [$]);
        foreach (addrs[i]) begin
            rk_rd   = 1'b1;
            rk_addr = addrs[i];
            tick();
            check_eq("burst_valid", rk_data_valid, 1'b1);
            check_eq("burst_data", rk_data, ref_read(addrs[i]));
        end
        rk_rd = 1'b0;
        tick();
        check_eq("valid_after_burst", rk_data_valid, 1'b0);
    endtask

    initial begin
        int           lat;
        logic [3:0]   addrs [$];
        logic [127:0] k2, k3;

        build_tables();
        rst       = 1'b1;
        key       = '0;
        key_valid = 1'b0;
        rk_rd     = 1'b0;
        rk_addr   = '0;
        tick();
        tick();
        check_eq("rst_key_ready", key_ready, 1'b1);
        check_eq("rst_keys_ready", keys_ready, 1'b0);
        check_eq("rst_rk_valid", rk_data_valid, 1'b0);
        check_eq("rst_rk_data", rk_data, 128'h0);
        rst = 1'b0;
        tick();

        // FIPS-197 A.1 vector
        load_key(fips(128'h2b7e151628aed2a6abf7158809cf4f3c));
        wait_keys(1'b0, lat);
        check_eq("a1_latency", lat, 10);
        check_eq("a1_key_ready_done", key_ready, 1'b1);
        addrs = '{4'd1};
        burst_read(addrs);
        check_eq("a1_rk1_const", rk_data, fips(128'ha0fafe1788542cb123a339392a6c7605));
        addrs = '{4'd10};
        burst_read(addrs);
        check_eq("a1_rk10_const", rk_data, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        addrs = '{};
        for (int a = 0; a <= 10; a++) addrs.push_back(4'(a));
        addrs.push_back(4'd11);
        addrs.push_back(4'd15);
        burst_read(addrs);

        // Re-key with zero key while reading addr 10 in the same cycle
        key       = '0;
        key_valid = 1'b1;
        rk_rd     = 1'b1;
        rk_addr   = 4'd10;
        tick();
        key_valid = 1'b0;
        rk_rd     = 1'b0;
        check_eq("rekey_old_valid", rk_data_valid, 1'b1);
        check_eq("rekey_old_data", rk_data, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        check_eq("rekey_keys_ready", keys_ready, 1'b0);
        model_expand(128'h0);
        wait_keys(1'b0, lat);
        check_eq("rekey_latency", lat, 10);
        addrs = '{4'd10};
        burst_read(addrs);
        check_eq("zero_rk10_const", rk_data, fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

        // key_valid held through expansion; the next key is taken only once DONE is reached
        k2 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        key       = k2;
        key_valid = 1'b1;
        tick();
        wait_keys(1'b0, lat);
        check_eq("held_latency", lat, 10);
        check_eq("held_key_ready_done", key_ready, 1'b1);
        key = k3;
        tick();
        key_valid = 1'b0;
        check_eq("held_reaccept_keys_ready", keys_ready, 1'b0);
        check_eq("held_reaccept_key_ready", key_ready, 1'b0);
        model_expand(k3);
        wait_keys(1'b1, lat);
        check_eq("held_k3_latency", lat, 10);
        addrs = '{4'd0, 4'd5, 4'd10};
        burst_read(addrs);

        for (int n = 0; n < 6; n++) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            wait_keys(1'b1, lat);
            check_eq("rand_latency", lat, 10);
            addrs = '{};
            for (int j = 0; j < 6; j++) addrs.push_back(4'($urandom_range(0, 15)));
            burst_read(addrs);
        end

        // Reset in the middle of an expansion
        addrs = '{4'd3};
        burst_read(addrs);
        load_key({$urandom, $urandom, $urandom, $urandom});
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_key_ready", key_ready, 1'b1);
        check_eq("midrst_keys_ready", keys_ready, 1'b0);
        check_eq("midrst_rk_valid", rk_data_valid, 1'b0);
        check_eq("midrst_rk_data", rk_data, 128'h0);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        check_eq("post_rst_keys_ready", keys_ready, 1'b0);
        check_eq("post_rst_key_ready", key_ready, 1'b1);
        rk_rd   = 1'b1;
        rk_addr = 4'd1;
        tick();
        rk_rd = 1'b0;
        check_eq("post_rst_rd_valid", rk_data_valid, 1'b0);
        check_eq("post_rst_rd_data", rk_data, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes128_key_scheduler.md
AES128_KEY_SCHEDULER -- requirements
Module: aes128_key_scheduler

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, giving the number of expanded round keys after round key 0; only 10 is legal, and other values SHALL fail elaboration.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 key  input  `AES128_KEY_SIZE  cipher key; FIPS-197 byte 0 sits at bits [7:0].
REQ-005 key_valid  input  1  key offered.
REQ-006 key_ready  output  1  block accepts a key.
REQ-007 rk_rd  input  1  round-key read request.
REQ-008 rk_addr  input  4  round-key index, 0..10.
REQ-009 rk_data  output  `AES128_KEY_SIZE  round key read result.
REQ-010 rk_data_valid  output  1  rk_data valid this cycle.
REQ-011 keys_ready  output  1  all 11 round keys are stored for the current key.

Function
REQ-012 SHALL implement the FSM states IDLE, EXPAND and DONE.
REQ-013 key_ready SHALL be 1 in IDLE and DONE and 0 in EXPAND.
REQ-014 Key acceptance: key_valid && key_ready at an edge stores key as round key 0, sets round counter to 1, sets rcon to 0x01, clears keys_ready, and enters EXPAND.
REQ-015 EXPAND, each cycle: compute one round key from the previous one via one expansion step with the runtime rcon, store it at the counter index, increment the counter, and set rcon = xtime(rcon) (0x80 -> 0x1b).
REQ-016 rcon SHALL occupy bits [7:0] of the word, matching the `AES_RCON_xx defines; sequence 01,02,04,08,10,20,40,80,1b,36.
REQ-017 After storing round key 10: enter DONE and set keys_ready=1; acceptance to keys_ready high is exactly 10 cycles.
REQ-018 key_valid during EXPAND SHALL be ignored (no handshake); the source holds key.
REQ-019 Read: rk_rd && keys_ready at an edge gives rk_data = stored key[rk_addr] and rk_data_valid=1 in the following cycle (1-cycle latency).
REQ-020 rk_rd with rk_addr > 10 SHALL give rk_data = 0 with rk_data_valid=1.
REQ-021 rk_rd while keys_ready=0 SHALL be ignored; the next cycle has rk_data_valid=0 and rk_data holds its previous value.
REQ-022 rk_rd in the same cycle as a key acceptance in DONE SHALL return the old stored key; keys_ready falls the next cycle.
REQ-023 Back-to-back reads SHALL be supported every cycle.
REQ-024 Key acceptance in DONE SHALL restart expansion (re-key) without passing through IDLE.
REQ-025 The round-key store SHALL be 11 x 128-bit registers; no other buffering.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, rcon 0x01, all 11 stored keys 0, rk_data 0, rk_data_valid 0 and keys_ready 0.
REQ-027 In reset, key_ready SHALL be 1 (IDLE).
REQ-028 Reset during EXPAND SHALL abandon expansion; after release the block waits for a new key.

Structure
REQ-029 `AES128_KEY_SIZE, `AES_WORD_SIZE, the word-slice macros and the rcon constants SHALL come from aes_defines.svh.
REQ-030 The FSM state enum and an xtime function SHALL be placed in the shared AES package.
REQ-031 There SHALL be one sub-module, aes128_key_expansion_step: a combinational step identical to the existing per-round expansion but with rcon as an 8-bit input, instantiated once and reusing aes_sbox.
REQ-032 The critical path SHALL be limited to one expansion step plus register.

Verification
REQ-033 FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> keys_ready 10 cycles after acceptance; rk_addr=1 reads a0fafe17 88542cb1 23a33939 2a6c7605; rk_addr=10 reads d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
REQ-034 Addresses 0..10 read back-to-back -> 11 consecutive valid cycles with correct data; rk_addr=11 or 15 -> data 0, valid 1.
REQ-035 rk_rd during EXPAND -> rk_data_valid stays 0; key_valid held in EXPAND -> key_ready 0 until DONE, then the key is accepted.
REQ-036 Re-key in DONE with an all-zero key, plus a simultaneous rk_rd of addr 10 -> old d014f9a8... returned, then after 10 cycles addr 10 reads b4ef5bcb 3e92e211 23e951cf 6f8f188e.
REQ-037 rst asserted at expansion cycle 5 -> all outputs at reset values immediately; after release, keys_ready 0 and a read returns valid 0.
